if_fetch_unit: RTL

//  Instruction-fetch stage. Drives the fetch-side inputs of the IF/ID pipeline register: PC, PC+4 and the fetched word.

---
 rtl/mips_pkg.sv | 18 +
 rtl/if_byte_loader.sv | 72 +++++++
 rtl/if_fetch_unit.sv | 96 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS-style pipeline: word encodings, PC width and
// primary opcodes.
package mips_pkg;

    localparam int          PC_W      = 32;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

    localparam logic [5:0]  OP_RTYPE  = 6'h00;
    localparam logic [5:0]  OP_J      = 6'h02;
    localparam logic [5:0]  OP_JAL    = 6'h03;
    localparam logic [5:0]  OP_BEQ    = 6'h04;
    localparam logic [5:0]  OP_BNE    = 6'h05;
    localparam logic [5:0]  OP_ADDI   = 6'h08;
    localparam logic [5:0]  OP_LW     = 6'h23;
    localparam logic [5:0]  OP_SW     = 6'h2B;

endpackage

// File: rtl/if_byte_loader.sv
// Debug byte-loader: packs big-endian bytes into 32-bit words and streams them
// into instruction memory from word 0 upwards, flagging writes past the end.
module if_byte_loader
    import mips_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              wr_en,
    input  logic [7:0]        wr_byte,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic [ADDR_W:0]   words_loaded,
    output logic              overflow
);

    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(MEM_DEPTH);

    logic [1:0]      cnt_q, cnt_d;
    logic [23:0]     part_q, part_d;
    logic [ADDR_W:0] ptr_q, ptr_d;
    logic            ovf_q, ovf_d;

    always_comb begin
        cnt_d  = cnt_q;
        part_d = part_q;
        ptr_d  = ptr_q;
        ovf_d  = ovf_q;
        we     = 1'b0;
        if (load_start) begin
            cnt_d = 2'd0;
            ptr_d = '0;
            ovf_d = 1'b0;
        end else if (wr_en) begin
            cnt_d  = cnt_q + 2'd1;
            part_d = {part_q[15:0], wr_byte};
            // The pointer stops at FULL so words_loaded saturates at MEM_DEPTH.
            if (cnt_q == 2'd3) begin
                if (ptr_q == FULL) begin
                    ovf_d = 1'b1;
                end else begin
                    we    = 1'b1;
                    ptr_d = ptr_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= 2'd0;
            part_q <= '0;
            ptr_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            part_q <= part_d;
            ptr_q  <= ptr_d;
            ovf_q  <= ovf_d;
        end
    end

    assign waddr        = ptr_q[ADDR_W-1:0];
    assign wdata        = {part_q, wr_byte};
    assign words_loaded = ptr_q;
    assign overflow     = ovf_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register with redirect/stall/halt priority,
// instruction memory with zero-latency read, and the debug loader.
module if_fetch_unit
    import mips_pkg::*;
#(
    parameter int          MEM_DEPTH = 256,
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = mips_pkg::HALT_WORD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clk_en,
    input  logic            stall,
    input  logic            id_pc_src,
    input  logic [31:0]     id_branch_target,
    input  logic            di_load_start,
    input  logic            di_wr_en,
    input  logic [7:0]      di_wr_byte,
    output logic [31:0]     if_pc,
    output logic [31:0]     if_pc_plus_4,
    output logic [31:0]     if_instruction,
    output logic            if_halted,
    output logic [ADDR_W:0] di_words_loaded,
    output logic            di_overflow
);

    logic [PC_W-1:0]   pc_q, pc_d;
    logic              halted_q, halted_d;
    logic [31:0]       imem [MEM_DEPTH];
    logic              ld_we;
    logic [ADDR_W-1:0] ld_waddr;
    logic [31:0]       ld_wdata;
    logic [ADDR_W-1:0] word_idx;
    logic              pc_in_range;

    if_byte_loader #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_loader (
        .clk          (clk),
        .reset        (reset),
        .load_start   (di_load_start),
        .wr_en        (di_wr_en),
        .wr_byte      (di_wr_byte),
        .we           (ld_we),
        .waddr        (ld_waddr),
        .wdata        (ld_wdata),
        .words_loaded (di_words_loaded),
        .overflow     (di_overflow)
    );

    always_ff @(posedge clk) begin
        if (ld_we) begin
            imem[ld_waddr] <= ld_wdata;
        end
    end

    // Once halted the stage emits NOPs, so the HALT word enters IF/ID only once.
    assign word_idx       = pc_q[ADDR_W+1:2];
    assign pc_in_range    = (pc_q[PC_W-1:ADDR_W+2] == '0);
    assign if_instruction = (pc_in_range && !halted_q) ? imem[word_idx] : NOP_WORD;
    assign if_pc          = pc_q;
    assign if_pc_plus_4   = pc_q + 32'd4;
    assign if_halted      = halted_q;

    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q;
        if (clk_en && !halted_q) begin
            if (id_pc_src) begin
                pc_d = id_branch_target;
            end else if (!stall) begin
                if (if_instruction == HALT_WORD) begin
                    halted_d = 1'b1;
                end else begin
                    pc_d = if_pc_plus_4;
                end
            end
        end
        if (di_load_start) begin
            halted_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

endmodule
